approx_mul_seq: RTL and testbench
=================================

APPROX_MUL_SEQ -- requirements
Module: approx_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4: unsigned operand width in bits; legal range 2..16.
REQ-002 SHALL have parameter TRUNC, default 2: number of least-significant product columns dropped in approximate mode; legal range 0..2*WIDTH.
REQ-003 SHALL have parameter ET, default 7: error threshold; unsigned, 2*WIDTH bits.
REQ-004 SHALL have one clock and a synchronous active-high reset, per the already-decided interface rule.
REQ-005 SHALL have port `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port `rst`, input, 1 bit: synchronous reset, active-high.
REQ-007 SHALL have port `in_valid`, input, 1 bit: operand pair offered.
REQ-008 SHALL have port `in_ready`, output, 1 bit: block can accept operands.
REQ-009 SHALL have port `in_a`, input, WIDTH bits: multiplicand, unsigned.
REQ-010 SHALL have port `in_b`, input, WIDTH bits: multiplier, unsigned.
REQ-011 SHALL have port `in_mode`, input, 1 bit: 0 = exact, 1 = approximate.
REQ-012 SHALL have port `out_valid`, output, 1 bit: result available.
REQ-013 SHALL have port `out_ready`, input, 1 bit: consumer accepts the result.
REQ-014 SHALL have port `out_prod`, output, 2*WIDTH bits: product.
REQ-015 SHALL have port `out_err`, output, 2*WIDTH bits: exact product minus returned product.
REQ-016 SHALL have port `out_exceed`, output, 1 bit: `out_err` > ET.

Function
REQ-017 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-018 IDLE SHALL drive in_ready=1, and `in_valid` & `in_ready` at a rising edge SHALL:
- capture a, b and mode;
- clear both accumulators and the step counter;
- move the FSM to RUN.
REQ-019 RUN SHALL run one step per cycle, with the step counter i counting 0..WIDTH-1.
REQ-020 In each RUN step where b[i]=1, the exact accumulator SHALL add (a<<i).
REQ-021 In each RUN step where b[i]=1, the approximate accumulator SHALL add (a<<i) with bits [TRUNC-1:0] forced to 0.
REQ-022 After step WIDTH-1 the FSM SHALL enter DONE, so `out_valid` rises exactly WIDTH cycles after the accepting edge.
REQ-023 DONE SHALL hold out_valid=1 and all outputs stable until an edge with `out_ready`=1, then return to IDLE.
REQ-024 A new operand pair SHALL NOT be accepted in the same cycle as the output handshake.
REQ-025 `in_ready` SHALL be 0 in RUN and DONE, and `in_valid` SHALL be ignored in those states.
REQ-026 With captured mode=0, outputs in DONE SHALL be: `out_prod` = exact product, `out_err` = 0, `out_exceed` = 0.
REQ-027 With captured mode=1, outputs in DONE SHALL be: `out_prod` = approximate product, `out_err` = exact − approximate (never negative), `out_exceed` = (`out_err` > ET).
REQ-028 Accumulators SHALL be 2*WIDTH bits wide, and their sums SHALL never overflow (maximum (2^WIDTH−1)^2).
REQ-029 TRUNC=0 SHALL make approximate mode bit-identical to exact mode, with `out_err`=0.
REQ-030 TRUNC=2*WIDTH SHALL give an approximate product of 0.
REQ-031 A changing `in_mode` or `in_a` after acceptance SHALL NOT affect the result in flight.

Reset
REQ-032 `rst`=1 at a rising edge SHALL force state IDLE, clear the counter and accumulators, and give out_valid=0, out_prod=0, out_err=0, out_exceed=0, in_ready=1 on the next cycle.
REQ-033 Reset during RUN or DONE SHALL abort the operation with no `out_valid` pulse.
REQ-034 Reset SHALL take priority over a simultaneous input or output handshake.

Structure
REQ-035 Package `approx_mul_pkg` SHALL hold the FSM state enum, the mode constants MODE_EXACT/MODE_APPROX, and elaboration checks on WIDTH and TRUNC.
REQ-036 Sub-module `approx_pp_mask` SHALL be combinational; it takes the shifted partial product and TRUNC and returns the column-masked value used by the approximate accumulator.

Verification
REQ-037 SHALL cover exact mode: WIDTH=4, mode=0, a=15, b=15 -> out_prod=225, out_err=0, out_exceed=0, out_valid 4 cycles after acceptance.
REQ-038 SHALL cover approximate mode: TRUNC=2, ET=7, mode=1, a=15, b=15 -> out_prod=220, out_err=5, out_exceed=0.
REQ-039 SHALL cover the threshold: TRUNC=2, ET=4, mode=1, a=15, b=15 -> out_err=5, out_exceed=1; and a=7, b=3 -> out_prod=16, out_err=5, out_exceed=1.
REQ-040 SHALL cover backpressure: out_ready=0 for 10 cycles in DONE -> outputs held and in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-041 SHALL cover reset mid-run: rst=1 at RUN step 2 -> next cycle IDLE, all outputs 0, and no out_valid pulse.
REQ-042 SHALL cover the TRUNC=0 equivalence: random sweep with mode=1 -> out_prod equals a*b and out_err=0 for all 256 operand pairs.

Source files
------------

// File: rtl/approx_mul_pkg.sv
// ---------------------------------------------------------------------------
// approx_mul_pkg
// Purpose : Shared definitions for the sequential approximate multiplier.
//           Holds the FSM state encoding, the operating-mode constants and
//           the helper functions the top level uses to check its parameters
//           and size its step counter while it is being elaborated.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package approx_mul_pkg;

  // Controller states. IDLE waits for operands, RUN does one
  // shift-and-add step per cycle, and DONE presents the result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Operating modes, as sampled from in_mode when operands are accepted.
  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Operand widths that the design supports.
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;

  // Returns 1 when the operand width is in the supported range.
  function automatic bit widthOk(input int width);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
  endfunction

  // Returns 1 when TRUNC is a legal number of columns for this width.
  // Dropping every column is allowed and gives a product of zero.
  function automatic bit truncOk(input int width, input int trunc);
    return (trunc >= 0) && (trunc <= 2 * width);
  endfunction

  // Returns the width of a counter that must reach WIDTH-1.
  function automatic int stepBits(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/approx_mul_seq_approx_pp_mask.sv
// ---------------------------------------------------------------------------
// approx_pp_mask
// Purpose : Combinational column mask for the approximate accumulator.
//           Forces the TRUNC least-significant columns of a shifted partial
//           product to zero and passes every other column through unchanged.
// Ports   : i_pp     - shifted partial product (PW bits)
//           o_masked - the same value with columns [TRUNC-1:0] cleared
// ---------------------------------------------------------------------------
module approx_pp_mask #(
  parameter int PW    = 8,
  parameter int TRUNC = 2
) (
  input  logic [PW-1:0] i_pp,
  output logic [PW-1:0] o_masked
);

  // Builds the keep-mask once while the design is elaborated. Columns at
  // or above TRUNC are kept. When TRUNC is PW or larger, no column is kept.
  function automatic logic [PW-1:0] keepMask();
    logic [PW-1:0] m;
    m = '0;
    for (int j = 0; j < PW; j++) begin
      m[j] = (j >= TRUNC);
    end
    return m;
  endfunction

  localparam logic [PW-1:0] KEEP = keepMask();

  assign o_masked = i_pp & KEEP;

endmodule

// File: rtl/approx_mul_seq.sv
// ---------------------------------------------------------------------------
// approx_mul_seq
// Purpose : Sequential shift-and-add multiplier with an optional approximate
//           mode. It keeps two accumulators in parallel. The exact one adds
//           every partial product unchanged. The approximate one adds every
//           partial product with its TRUNC low columns dropped. The captured
//           mode selects which accumulator is returned, and the error is
//           reported against the exact product.
// Ports   : clk        - clock, every state update is on its rising edge
//           rst        - synchronous reset, active high
//           in_valid   - an operand pair is offered
//           in_ready   - the block can accept operands (IDLE only)
//           in_a       - multiplicand, unsigned, WIDTH bits
//           in_b       - multiplier, unsigned, WIDTH bits
//           in_mode    - 0 = exact, 1 = approximate
//           out_valid  - a result is available (DONE only)
//           out_ready  - the consumer accepts the result
//           out_prod   - returned product, 2*WIDTH bits
//           out_err    - exact product minus returned product
//           out_exceed - out_err is greater than ET
// ---------------------------------------------------------------------------
module approx_mul_seq
  import approx_mul_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter int               TRUNC = 2,
  parameter logic [2*WIDTH-1:0] ET  = (2*WIDTH)'(7)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [2*WIDTH-1:0] out_err,
  output logic               out_exceed
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = stepBits(WIDTH);

  // Stop elaboration if the parameters fall outside the supported range.
  if (!widthOk(WIDTH)) begin : g_badWidth
    $error("approx_mul_seq: WIDTH must be in 2..16");
  end
  if (!truncOk(WIDTH, TRUNC)) begin : g_badTrunc
    $error("approx_mul_seq: TRUNC must be in 0..2*WIDTH");
  end

  state_e          r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic            r_mode;
  logic [SW-1:0]   r_step;
  logic [PW-1:0]   r_accExact;
  logic [PW-1:0]   r_accApprox;

  logic [PW-1:0]   w_pp;
  logic [PW-1:0]   w_ppMasked;
  logic            w_bitSet;
  logic            w_lastStep;
  logic            w_done;
  logic            w_approx;
  logic [PW-1:0]   w_err;

  // Partial product for the current step. The captured multiplicand is
  // widened before the shift so that its top bits are kept.
  assign w_pp       = PW'(r_a) << r_step;
  assign w_bitSet   = r_b[r_step];
  assign w_lastStep = (r_step == SW'(WIDTH - 1));

  approx_pp_mask #(
    .PW    (PW),
    .TRUNC (TRUNC)
  ) u_mask (
    .i_pp     (w_pp),
    .o_masked (w_ppMasked)
  );

  // Controller and datapath registers. Reset takes priority over both
  // handshakes. Operands are accepted only in IDLE, so a result handshake
  // in DONE always spends one cycle in IDLE before the next capture.
  // Because the operands and the mode are captured locally, later changes
  // on the inputs cannot disturb a multiplication that is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= MODE_EXACT;
      r_step      <= '0;
      r_accExact  <= '0;
      r_accApprox <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a         <= in_a;
            r_b         <= in_b;
            r_mode      <= in_mode;
            r_step      <= '0;
            r_accExact  <= '0;
            r_accApprox <= '0;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_bitSet) begin
            r_accExact  <= r_accExact + w_pp;
            r_accApprox <= r_accApprox + w_ppMasked;
          end
          if (w_lastStep) begin
            r_state <= ST_DONE;
          end else begin
            r_step <= r_step + SW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode. Outputs stay at zero unless the block is in DONE. The
  // approximate accumulator never exceeds the exact one, because masking
  // only removes bits, so the subtraction cannot wrap.
  assign w_done    = (r_state == ST_DONE);
  assign w_approx  = (r_mode == MODE_APPROX);
  assign w_err     = r_accExact - r_accApprox;

  assign in_ready   = (r_state == ST_IDLE);
  assign out_valid  = w_done;
  assign out_prod   = !w_done ? '0 : (w_approx ? r_accApprox : r_accExact);
  assign out_err    = (w_done && w_approx) ? w_err : '0;
  assign out_exceed = w_done && w_approx && (w_err > ET);

endmodule

// File: tb/tb_approx_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_approx_mul_seq
// Purpose : Self-checking bench for approx_mul_seq. Four instances share the
//           same stimulus and differ only in TRUNC and ET:
//             dut0 TRUNC=2 ET=7, dut1 TRUNC=2 ET=4,
//             dut2 TRUNC=0 ET=7, dut3 TRUNC=8 ET=7.
//           A behavioural reference, built from cycle timestamps and plain
//           arithmetic, predicts the handshakes and the result of every
//           instance. A negedge compare process checks all of them.
// ---------------------------------------------------------------------------
module tb_approx_mul_seq;

  localparam int WIDTH = 4;
  localparam int PW    = 2 * WIDTH;
  localparam int NDUT  = 4;

  // Per-instance TRUNC value.
  function automatic int truncOf(input int g);
    case (g)
      0: return 2;
      1: return 2;
      2: return 0;
      default: return 8;
    endcase
  endfunction

  // Per-instance error threshold.
  function automatic int etOf(input int g);
    return (g == 1) ? 4 : 7;
  endfunction

  logic                clk = 1'b0;
  logic                rst;
  logic                inValid;
  logic [WIDTH-1:0]    inA;
  logic [WIDTH-1:0]    inB;
  logic                inMode;
  logic                outReady;
  logic [NDUT-1:0]     inReady;
  logic [NDUT-1:0]     outValid;
  logic [NDUT-1:0]     outExceed;
  logic [NDUT-1:0][PW-1:0] outProd;
  logic [NDUT-1:0][PW-1:0] outErr;

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    approx_mul_seq #(
      .WIDTH (WIDTH),
      .TRUNC (truncOf(g)),
      .ET    (PW'(etOf(g)))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (inValid),
      .in_ready   (inReady[g]),
      .in_a       (inA),
      .in_b       (inB),
      .in_mode    (inMode),
      .out_valid  (outValid[g]),
      .out_ready  (outReady),
      .out_prod   (outProd[g]),
      .out_err    (outErr[g]),
      .out_exceed (outExceed[g])
    );
  end

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Reference product. In approximate mode, each selected partial product
  // loses its TRUNC low columns, here done by a right shift and a left shift.
  function automatic int refProd(input int a, input int b, input bit mode, input int trunc);
    longint s;
    if (!mode) return a * b;
    s = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (((b >> i) & 1) == 1) s += ((longint'(a) << i) >> trunc) << trunc;
    end
    return int'(s);
  endfunction

  // Compares one value and records the outcome.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural reference. It tracks whether a job is in flight and the
  // edge on which the job was accepted. The result is due WIDTH edges after
  // acceptance, and it is held until an edge with out_ready high.
  int edgeCnt    = 0;
  int acceptEdge = 0;
  bit mBusy      = 1'b0;
  bit mValid     = 1'b0;
  bit mJustReset = 1'b0;
  bit started    = 1'b0;
  int mA = 0;
  int mB = 0;
  bit mMode = 1'b0;

  always @(posedge clk) begin
    edgeCnt++;
    mJustReset = 1'b0;
    if (rst === 1'b1) begin
      mBusy      = 1'b0;
      mJustReset = 1'b1;
      started    = 1'b1;
    end else if (mBusy) begin
      if (mValid && outReady) mBusy = 1'b0;
    end else if (inValid === 1'b1) begin
      mBusy      = 1'b1;
      acceptEdge = edgeCnt;
      mA         = int'(inA);
      mB         = int'(inB);
      mMode      = inMode;
    end
    mValid = mBusy && ((edgeCnt - acceptEdge) >= WIDTH);
  end

  // Compare process, run on every falling edge after the first reset.
  always @(negedge clk) begin
    if (started) begin
      for (int g = 0; g < NDUT; g++) begin
        checkOutput($sformatf("dut%0d in_ready", g), 32'(inReady[g]), 32'(!mBusy));
        checkOutput($sformatf("dut%0d out_valid", g), 32'(outValid[g]), 32'(mValid));
        if (mValid) begin
          int p;
          int e;
          p = refProd(mA, mB, mMode, truncOf(g));
          e = mA * mB - p;
          checkOutput($sformatf("dut%0d out_prod %0dx%0d m%0d", g, mA, mB, mMode),
                      32'(outProd[g]), 32'(p));
          checkOutput($sformatf("dut%0d out_err %0dx%0d m%0d", g, mA, mB, mMode),
                      32'(outErr[g]), 32'(e));
          checkOutput($sformatf("dut%0d out_exceed %0dx%0d m%0d", g, mA, mB, mMode),
                      32'(outExceed[g]), 32'(e > etOf(g)));
        end else if (mJustReset) begin
          checkOutput($sformatf("dut%0d reset out_prod", g), 32'(outProd[g]), 32'd0);
          checkOutput($sformatf("dut%0d reset out_err", g), 32'(outErr[g]), 32'd0);
          checkOutput($sformatf("dut%0d reset out_exceed", g), 32'(outExceed[g]), 32'd0);
        end
      end
    end
  end

  // Offers an operand pair and waits for the result. While the job runs,
  // the inputs are scrambled to show that they are ignored. The task
  // returns 1 ns after the edge that raises out_valid.
  task automatic applyStimulus(input int a, input int b, input bit mode);
    int waited;
    inValid = 1'b1;
    inA     = WIDTH'(a);
    inB     = WIDTH'(b);
    inMode  = mode;
    @(posedge clk); #1;
    waited = 0;
    while (outValid[0] !== 1'b1 && waited < WIDTH + 4) begin
      inValid = 1'($urandom);
      inA     = WIDTH'($urandom);
      inB     = WIDTH'($urandom);
      inMode  = 1'($urandom);
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("result latency", 32'(waited), 32'(WIDTH));
  endtask

  // Holds off the consumer for holdCycles and then completes the output
  // handshake. in_valid is high on the handshake edge, and it must not be
  // accepted on that edge.
  task automatic releaseResult(input int holdCycles);
    outReady = 1'b0;
    for (int d = 0; d < holdCycles; d++) begin
      inValid = 1'($urandom);
      inA     = WIDTH'($urandom);
      @(posedge clk); #1;
    end
    outReady = 1'b1;
    inValid  = 1'b1;
    inA      = WIDTH'($urandom);
    inB      = WIDTH'($urandom);
    @(posedge clk); #1;
    outReady = 1'b0;
    inValid  = 1'b0;
  endtask

  // Watchdog that stops the run if it never finishes.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    rst      = 1'b1;
    inValid  = 1'b0;
    inA      = '0;
    inB      = '0;
    inMode   = 1'b0;
    outReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset in_ready", 32'(inReady[0]), 32'd1);
    checkOutput("reset out_valid", 32'(outValid[0]), 32'd0);
    checkOutput("reset out_prod", 32'(outProd[0]), 32'd0);

    // Hand-computed values that pin the reference model.
    checkOutput("model 15x15 exact", 32'(refProd(15, 15, 1'b0, 2)), 32'd225);
    checkOutput("model 15x15 approx", 32'(refProd(15, 15, 1'b1, 2)), 32'd220);
    checkOutput("model 7x3 approx", 32'(refProd(7, 3, 1'b1, 2)), 32'd16);
    checkOutput("model trunc8", 32'(refProd(13, 11, 1'b1, 8)), 32'd0);

    // Exact mode, 15 x 15.
    applyStimulus(15, 15, 1'b0);
    checkOutput("exact prod", 32'(outProd[0]), 32'd225);
    checkOutput("exact err", 32'(outErr[0]), 32'd0);
    checkOutput("exact exceed", 32'(outExceed[0]), 32'd0);
    releaseResult(0);

    // Approximate mode, 15 x 15, against both thresholds and the edge TRUNCs.
    applyStimulus(15, 15, 1'b1);
    checkOutput("approx prod", 32'(outProd[0]), 32'd220);
    checkOutput("approx err", 32'(outErr[0]), 32'd5);
    checkOutput("approx exceed et7", 32'(outExceed[0]), 32'd0);
    checkOutput("approx exceed et4", 32'(outExceed[1]), 32'd1);
    checkOutput("trunc0 prod", 32'(outProd[2]), 32'd225);
    checkOutput("trunc8 prod", 32'(outProd[3]), 32'd0);
    checkOutput("trunc8 err", 32'(outErr[3]), 32'd225);
    releaseResult(1);

    // Approximate mode, 7 x 3.
    applyStimulus(7, 3, 1'b1);
    checkOutput("7x3 prod", 32'(outProd[1]), 32'd16);
    checkOutput("7x3 err", 32'(outErr[1]), 32'd5);
    checkOutput("7x3 exceed et4", 32'(outExceed[1]), 32'd1);
    releaseResult(0);

    // Backpressure: result held for 10 cycles, then released.
    applyStimulus(9, 13, 1'b1);
    releaseResult(10);
    checkOutput("after release in_ready", 32'(inReady[0]), 32'd1);
    checkOutput("after release out_valid", 32'(outValid[0]), 32'd0);

    // Reset at RUN step 2 aborts the job without an out_valid pulse.
    inValid = 1'b1;
    inA     = 4'd11;
    inB     = 4'd14;
    inMode  = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrun reset in_ready", 32'(inReady[0]), 32'd1);
    checkOutput("midrun reset out_valid", 32'(outValid[0]), 32'd0);
    checkOutput("midrun reset out_prod", 32'(outProd[0]), 32'd0);
    checkOutput("midrun reset out_err", 32'(outErr[0]), 32'd0);
    for (int c = 0; c < WIDTH + 2; c++) begin
      @(posedge clk); #1;
      checkOutput("midrun no valid pulse", 32'(outValid), 32'd0);
    end

    // Full operand sweep in approximate mode. dut2 (TRUNC=0) must be exact.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(a, b, 1'b1);
        checkOutput("trunc0 sweep prod", 32'(outProd[2]), 32'(a * b));
        checkOutput("trunc0 sweep err", 32'(outErr[2]), 32'd0);
        releaseResult($urandom_range(0, 2));
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk); #1;
        end
      end
    end

    // Random operands and modes with random consumer stalls.
    for (int n = 0; n < 100; n++) begin
      applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom));
      releaseResult($urandom_range(0, 4));
    end

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
